// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing source for the drawing pipeline.
// Ports:
//   clk, rst (sync, active-low), pix_en
//   hcount_out, vcount_out, hsync_out, vsync_out,
//   hblnk_out, vblnk_out, frame_start_out
//   frame_cnt_out (only with VGA_TIMING_FRAME_CNT_EN)
// Optional: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_timing #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BACK    = 88,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BACK    = 23,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start_out
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_out
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Window bounds are 12 bits so a 2048-wide raster still compares correctly.
    localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
    localparam logic [11:0] H_SBEG = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SEND = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_VIS  = 12'(V_VISIBLE);
    localparam logic [11:0] V_SBEG = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SEND = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic        h_sync_win;
    logic        v_sync_win;

    // Status flags are derived from the next counts so that, once registered,
    // they line up with the counts of the same cycle.
    always_comb begin
        h_wrap = (hcount_out == H_LAST);
        v_wrap = (vcount_out == V_LAST);
        h_nxt  = h_wrap ? 11'd0 : hcount_out + 11'd1;
        v_nxt  = vcount_out;
        if (h_wrap) begin
            v_nxt = v_wrap ? 11'd0 : vcount_out + 11'd1;
        end
        h_ext      = {1'b0, h_nxt};
        v_ext      = {1'b0, v_nxt};
        h_sync_win = (h_ext >= H_SBEG) && (h_ext < H_SEND);
        v_sync_win = (v_ext >= V_SBEG) && (v_ext < V_SEND);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_out      <= 11'd0;
            vcount_out      <= 11'd0;
            hsync_out       <= ~SYNC_POL;
            vsync_out       <= ~SYNC_POL;
            hblnk_out       <= 1'b0;
            vblnk_out       <= 1'b0;
            frame_start_out <= 1'b0;
        end else if (pix_en) begin
            hcount_out      <= h_nxt;
            vcount_out      <= v_nxt;
            hsync_out       <= h_sync_win ? SYNC_POL : ~SYNC_POL;
            vsync_out       <= v_sync_win ? SYNC_POL : ~SYNC_POL;
            hblnk_out       <= (h_ext >= H_VIS);
            vblnk_out       <= (v_ext >= V_VIS);
            frame_start_out <= h_wrap & v_wrap;
        end else begin
            // Stalled: everything holds except the one-shot frame pulse.
            frame_start_out <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_out <= 16'd0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt_out <= frame_cnt_out + 16'd1;
        end
    end
`endif

endmodule
